iob_cache_be_mem: RTL and testbench

- IOb native responder (slave) that terminates the cache back-end interface (be_req/be_addr/be_wdata/be_wstrb/be_rdata/be_ack).
- Models the next-level memory with an internal byte-writable RAM, a programmable response latency and an external stall input.
- Used as the back-end memory in cache simulation benches and as an on-chip backing store in small systems.
- Accepts back-to-back requests, including a new request presented in the same cycle as the previous ack.

---
 rtl/iob_cache_be_mem_pkg.sv | 28 ++
 rtl/iob_ram_sp_be.sv | 36 +++
 rtl/iob_cache_be_mem.sv | 128 ++++++++++++
 tb/tb_iob_cache_be_mem.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_be_mem_pkg.sv
// Shared helpers for the cache back-end memory model: state encoding,
// byte-lane sizing and countdown counter width.
package iob_cache_be_mem_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT
  } state_t;

  // Number of byte lanes in a data word.
  function automatic int nBytes(input int dataW);
    return dataW / 8;
  endfunction

  // Width of the byte offset inside a word (0 for an 8-bit data path).
  function automatic int nBytesW(input int dataW);
    return $clog2(dataW / 8);
  endfunction

  // Countdown width: $clog2(LATENCY), but never narrower than one bit.
  function automatic int cntW(input int latency);
    return (latency > 2) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port RAM with per-byte write enables and a synchronous read port.
// The read register only loads on read accesses, so a write leaves the
// previously read word on d_o.
module iob_ram_sp_be #(
  parameter int MEM_ADDR_W = 10,
  parameter int DATA_W     = 32,
  parameter     INIT_FILE  = "none"
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [DATA_W/8-1:0]   we_i,
  input  logic [MEM_ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0]     d_i,
  output logic [DATA_W-1:0]     d_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**MEM_ADDR_W];

  // One access per cycle: masked byte write, or registered word read.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (|we_i) begin
        for (int i = 0; i < NB; i++) begin
          if (we_i[i]) begin
            mem[addr_i][8*i +: 8] <= d_i[8*i +: 8];
          end
        end
      end else begin
        d_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/iob_cache_be_mem.sv
// IOb native responder terminating the cache back-end port. Models the
// next-level memory with a byte-writable RAM, a programmable latency and a
// stall input that freezes both acceptance and the countdown.
module iob_cache_be_mem
  import iob_cache_be_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int LATENCY    = 1,
  parameter     INIT_FILE  = "none"
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                req_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ack_o,
  input  logic                stall_i
);

  localparam int NB    = nBytes(DATA_W);
  localparam int NB_W  = nBytesW(DATA_W);
  localparam int CNT_W = cntW(LATENCY);

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [MEM_ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [NB-1:0]           wstrb_q;
  logic                    ack_q;
  logic                    rdValid_q;

  logic                    accept;
  logic                    access;
  logic [MEM_ADDR_W-1:0]   addrIdx;
  logic [MEM_ADDR_W-1:0]   accIdx;
  logic [DATA_W-1:0]       accWdata;
  logic [NB-1:0]           accWstrb;
  logic                    ramEn;
  logic [DATA_W-1:0]       ramDout;
  logic                    unusedAddr;

  // Word index; upper bits alias modulo the RAM size, byte offset dropped.
  assign addrIdx    = addr_i[MEM_ADDR_W+NB_W-1:NB_W];
  assign unusedAddr = ^addr_i;

  assign accept = (state_q == IDLE) && req_i && !stall_i;

  // Choose where the access comes from: the live port for single-cycle
  // latency, otherwise the registered request once the countdown expires.
  always_comb begin
    access   = 1'b0;
    accIdx   = addrIdx;
    accWdata = wdata_i;
    accWstrb = wstrb_i;
    if (LATENCY == 1) begin
      access = accept;
    end else begin
      access   = (state_q == WAIT) && !stall_i && (cnt_q == '0);
      accIdx   = addr_q;
      accWdata = wdata_q;
      accWstrb = wstrb_q;
    end
  end

  // Gate with reset so nothing is committed while the responder is held.
  assign ramEn = access && rst_n_i;

  iob_ram_sp_be #(
    .MEM_ADDR_W (MEM_ADDR_W),
    .DATA_W     (DATA_W),
    .INIT_FILE  (INIT_FILE)
  ) uRam (
    .clk_i  (clk_i),
    .en_i   (ramEn),
    .we_i   (accWstrb),
    .addr_i (accIdx),
    .d_i    (accWdata),
    .d_o    (ramDout)
  );

  // Request FSM with countdown, request register and registered ack.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ack_q     <= 1'b0;
      rdValid_q <= 1'b0;
    end else begin
      ack_q <= access;
      if (access && (accWstrb == '0)) begin
        rdValid_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept && (LATENCY > 1)) begin
            addr_q  <= addrIdx;
            wdata_q <= wdata_i;
            wstrb_q <= wstrb_i;
            cnt_q   <= CNT_W'(LATENCY - 2);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!stall_i) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data reads as zero until the first read after reset.
  assign rdata_o = rdValid_q ? ramDout : '0;
  assign ack_o   = ack_q;

endmodule

// File: tb/tb_iob_cache_be_mem.sv
// Directed bench for iob_cache_be_mem: three instances (latency 1 with a
// 16-word RAM, latency 3, latency 4) driven from one sequential script.
module tb_iob_cache_be_mem;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] expRdata;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        req   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic        stall [3];
  logic [31:0] rdata [3];
  logic        ack   [3];

  int checks;
  int failures;

  iob_cache_be_mem #(.MEM_ADDR_W(4), .LATENCY(1)) uLat1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .wstrb_i(wstrb[0]), .rdata_o(rdata[0]),
    .ack_o(ack[0]), .stall_i(stall[0])
  );

  iob_cache_be_mem #(.LATENCY(3)) uLat3 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .wstrb_i(wstrb[1]), .rdata_o(rdata[1]),
    .ack_o(ack[1]), .stall_i(stall[1])
  );

  iob_cache_be_mem #(.LATENCY(4)) uLat4 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[2]), .addr_i(addr[2]),
    .wdata_i(wdata[2]), .wstrb_i(wstrb[2]), .rdata_o(rdata[2]),
    .ack_o(ack[2]), .stall_i(stall[2])
  );

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one request on instance k and wait for its ack, holding stall
  // high for cycle offsets [stStart, stStart+stLen). Returns the number of
  // cycles from presentation to the ack cycle, or -1 on timeout. req is left
  // high so the caller can chain a back-to-back request in the ack cycle.
  task automatic applyStimulus(input int k, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int stStart, input int stLen,
                               output int cycles);
    int  c;
    bit  got;
    req[k]   = 1'b1;
    addr[k]  = a;
    wdata[k] = d;
    wstrb[k] = s;
    stall[k] = (0 >= stStart) && (0 < stStart + stLen);
    c   = 0;
    got = 1'b0;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      if (ack[k]) got = 1'b1;
      else stall[k] = (c >= stStart) && (c < stStart + stLen);
    end
    stall[k] = 1'b0;
    if (!got) begin
      checkOutput($sformatf("ackTimeout%0d", k), 32'd0, 32'd1);
      cycles = -1;
    end else begin
      cycles = c;
    end
  endtask

  // Count ack pulses on instance k over n idle cycles; none are expected.
  task automatic checkIdle(input int k, input int n, input string name);
    int pulses;
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (ack[k]) pulses++;
    end
    checkOutput(name, 32'(pulses), 32'd0);
  endtask

  vec_t vecs[16];
  int   cyc;

  // Main script: reset, latency-1 table, latency-3 stall cases, latency-4 reset abort.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wstrb[k] = '0; stall[k] = 1'b0;
    end

    vecs[0]  = '{32'h10, 32'hDEADBEEF, 4'hF, 32'h00000000};
    vecs[1]  = '{32'h10, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[2]  = '{32'h20, 32'h11223344, 4'hF, 32'hDEADBEEF};
    vecs[3]  = '{32'h20, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF};
    vecs[4]  = '{32'h20, 32'h0,        4'h0, 32'h11BB33DD};
    vecs[5]  = '{32'h28, 32'h11223344, 4'hF, 32'h11BB33DD};
    vecs[6]  = '{32'h28, 32'hAABBCCDD, 4'h4, 32'h11BB33DD};
    vecs[7]  = '{32'h28, 32'h0,        4'h0, 32'h11BB3344};
    vecs[8]  = '{32'h00, 32'h5A5A5A5A, 4'hF, 32'h11BB3344};
    vecs[9]  = '{32'h40, 32'h0,        4'h0, 32'h5A5A5A5A};
    vecs[10] = '{32'h50, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[11] = '{32'h3C, 32'hFFFFFFFF, 4'hF, 32'hDEADBEEF};
    vecs[12] = '{32'h7C, 32'h00000000, 4'h2, 32'hDEADBEEF};
    vecs[13] = '{32'h3C, 32'h0,        4'h0, 32'hFFFF00FF};
    vecs[14] = '{32'h22, 32'h0,        4'h0, 32'h11BB33DD};
    vecs[15] = '{32'h28, 32'h0,        4'h0, 32'h11BB3344};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rstAck%0d", k), 32'(ack[k]), 32'd0);
      checkOutput($sformatf("rstRdata%0d", k), rdata[k], 32'd0);
    end
    rst_n = 1'b1;
    checkIdle(0, 3, "idleNoAck");

    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, -1, 0, cyc);
      checkOutput($sformatf("l1Lat%0d", i), 32'(cyc), 32'd1);
      checkOutput($sformatf("l1Rdata%0d", i), rdata[0], vecs[i].expRdata);
    end
    req[0] = 1'b0;
    checkIdle(0, 3, "l1NoExtraAck");

    applyStimulus(1, 32'h100, 32'h12345678, 4'hF, -1, 0, cyc);
    req[1] = 1'b0;
    checkOutput("l3LatPlain", 32'(cyc), 32'd3);
    checkOutput("l3RdataAfterWr", rdata[1], 32'd0);
    checkIdle(1, 2, "l3NoExtraAck");
    applyStimulus(1, 32'h100, 32'h0, 4'h0, 1, 2, cyc);
    req[1] = 1'b0;
    checkOutput("l3LatWaitStall", 32'(cyc), 32'd5);
    checkOutput("l3RdataWaitStall", rdata[1], 32'h12345678);
    applyStimulus(1, 32'h104, 32'hCAFEF00D, 4'hF, 0, 2, cyc);
    checkOutput("l3LatAcceptStall", 32'(cyc), 32'd5);
    checkOutput("l3RdataHeld", rdata[1], 32'h12345678);
    applyStimulus(1, 32'h104, 32'h0, 4'h0, -1, 0, cyc);
    req[1] = 1'b0;
    checkOutput("l3LatB2b", 32'(cyc), 32'd3);
    checkOutput("l3RdataB2b", rdata[1], 32'hCAFEF00D);

    applyStimulus(2, 32'h30, 32'h01020304, 4'hF, -1, 0, cyc);
    req[2] = 1'b0;
    checkOutput("l4LatWr", 32'(cyc), 32'd4);
    applyStimulus(2, 32'h30, 32'h0, 4'h0, -1, 0, cyc);
    req[2] = 1'b0;
    checkOutput("l4LatRd", 32'(cyc), 32'd4);
    checkOutput("l4Rdata", rdata[2], 32'h01020304);

    req[2] = 1'b1; addr[2] = 32'h30; wdata[2] = 32'hFFFFFFFF; wstrb[2] = 4'hF;
    @(negedge clk);
    checkOutput("l4NoEarlyAck", 32'(ack[2]), 32'd0);
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    req[2] = 1'b0;
    #1;
    checkOutput("asyncRstRdata2", rdata[2], 32'd0);
    checkOutput("asyncRstRdata0", rdata[0], 32'd0);
    checkOutput("asyncRstRdata1", rdata[1], 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkIdle(2, 8, "l4NoAckAfterRst");
    checkOutput("l4RdataAfterRst", rdata[2], 32'd0);
    applyStimulus(2, 32'h30, 32'h0, 4'h0, -1, 0, cyc);
    req[2] = 1'b0;
    checkOutput("l4LatAfterRst", 32'(cyc), 32'd4);
    checkOutput("l4WriteDropped", rdata[2], 32'h01020304);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
